// File: rtl/chan_pkg.sv
// rtl/chan_pkg.sv - shared types, LFSR taps and popcount for the channel error injector
package chan_pkg;

  typedef enum logic [1:0] {
    CH_OFF      = 2'd0,
    CH_PERIODIC = 2'd1,
    CH_BURST    = 2'd2,
    CH_RANDOM   = 2'd3
  } chan_mode_e;

  // Fibonacci feedback taps x^16 + x^14 + x^13 + x^11 + 1 (state bits 15,13,12,10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Width of the popcount result; covers symbols up to 64 bits
  localparam int POP_W = 7;

  function automatic logic [POP_W-1:0] popcount(input logic [63:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) begin
      n = n + {{(POP_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/chan_err_injector_lfsr16.sv
// rtl/chan_err_injector_lfsr16.sv - 16-bit Fibonacci LFSR with load and step enable
module lfsr16
  import chan_pkg::*;
#(
  parameter logic [15:0] RST_VAL = 16'hACE1,
  parameter int          OUT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [15:0]      seed_i,
  output logic [OUT_W-1:0] state_o
);

  logic [15:0] r_state;
  logic [15:0] w_cur;
  logic [15:0] w_next;

  // A load takes effect in the same cycle, so a coincident step starts from the seed
  assign w_cur   = load_i ? seed_i : r_state;
  assign w_next  = {w_cur[14:0], ^(w_cur & LFSR_TAPS)};
  assign state_o = w_cur[OUT_W-1:0];

  // State register: step once per enabled cycle, otherwise hold (or take the seed)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RST_VAL;
    end else if (en_i) begin
      r_state <= w_next;
    end else begin
      r_state <= w_cur;
    end
  end

endmodule

// File: rtl/chan_err_injector.sv
// rtl/chan_err_injector.sv - channel model flipping masked symbol bits; CHAN_PER_BIT_CNT_EN adds per-bit counters
module chan_err_injector
  import chan_pkg::*;
#(
  parameter int          SYM_W     = 2,
  parameter int          PHASE_W   = 8,
  parameter int          CNT_W     = 16,
  parameter int          WINDOW    = 256,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid_i,
  input  logic [SYM_W-1:0]   in_sym_i,
  input  logic               cfg_load_i,
  input  logic [1:0]         cfg_mode_i,
  input  logic [PHASE_W-1:0] cfg_period_i,
  input  logic [PHASE_W-1:0] cfg_burst_i,
  input  logic [SYM_W-1:0]   cfg_mask_i,
  input  logic               clr_i,
  output logic               out_valid_o,
  output logic [SYM_W-1:0]   out_sym_o,
  output logic               out_err_o,
  output logic [CNT_W-1:0]   word_ct_o,
  output logic [CNT_W-1:0]   bad_bit_ct_o,
  output logic               window_done_o
`ifdef CHAN_PER_BIT_CNT_EN
  ,
  output logic [CNT_W-1:0]   bit_err_ct_o [SYM_W]
`endif
);

  localparam logic [PHASE_W-1:0] PH_ONE   = {{(PHASE_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   WIN_C    = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0]   WIN_LAST = CNT_W'(WINDOW - 1);

  // Latched configuration and pattern position
  chan_mode_e         r_mode;
  logic [PHASE_W-1:0] r_period;
  logic [PHASE_W-1:0] r_burst;
  logic [SYM_W-1:0]   r_mask;
  logic [PHASE_W-1:0] r_phase;

  // Output and statistics registers
  logic               r_out_valid;
  logic [SYM_W-1:0]   r_out_sym;
  logic               r_out_err;
  logic [CNT_W-1:0]   r_word_ct;
  logic [CNT_W-1:0]   r_bad_ct;
  logic               r_done;

  // Effective config for this cycle: a load applies to the word arriving with it
  chan_mode_e         w_mode;
  logic [PHASE_W-1:0] w_period;
  logic [PHASE_W-1:0] w_burst;
  logic [SYM_W-1:0]   w_mask;
  logic [PHASE_W-1:0] w_phase;
  logic [PHASE_W-1:0] w_lfsr;

  logic               w_hit;
  logic               w_inject;
  logic [SYM_W-1:0]   w_flip;
  logic [POP_W-1:0]   w_pop;
  logic               w_count_en;
  logic [CNT_W:0]     w_bad_sum;
  logic [CNT_W-1:0]   w_bad_next;

  assign w_mode   = cfg_load_i ? chan_mode_e'(cfg_mode_i) : r_mode;
  assign w_period = cfg_load_i ? cfg_period_i : r_period;
  assign w_burst  = cfg_load_i ? cfg_burst_i  : r_burst;
  assign w_mask   = cfg_load_i ? cfg_mask_i   : r_mask;
  assign w_phase  = cfg_load_i ? '0           : r_phase;

  lfsr16 #(
    .RST_VAL (LFSR_SEED),
    .OUT_W   (PHASE_W)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .en_i    (in_valid_i),
    .load_i  (cfg_load_i),
    .seed_i  (LFSR_SEED),
    .state_o (w_lfsr)
  );

  // Per-mode injection decision on the current phase / LFSR value
  always_comb begin
    w_hit = 1'b0;
    case (w_mode)
      CH_PERIODIC: w_hit = (w_phase == (w_period - PH_ONE));
      CH_BURST:    w_hit = (w_phase < w_burst);
      CH_RANDOM:   w_hit = (w_lfsr < w_burst);
      default:     w_hit = 1'b0;
    endcase
  end

  // A zero period disables injection regardless of mode
  assign w_inject   = in_valid_i && (w_period != '0) && w_hit;
  assign w_flip     = w_inject ? w_mask : '0;
  assign w_pop      = popcount(64'(w_flip));
  assign w_count_en = in_valid_i && (r_word_ct < WIN_C);
  assign w_bad_sum  = {1'b0, r_bad_ct} + {{(CNT_W+1-POP_W){1'b0}}, w_pop};
  assign w_bad_next = w_bad_sum[CNT_W] ? '1 : w_bad_sum[CNT_W-1:0];

  // Config latch on the load strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode   <= CH_OFF;
      r_period <= '0;
      r_burst  <= '0;
      r_mask   <= '0;
    end else if (cfg_load_i) begin
      r_mode   <= chan_mode_e'(cfg_mode_i);
      r_period <= cfg_period_i;
      r_burst  <= cfg_burst_i;
      r_mask   <= cfg_mask_i;
    end
  end

  // Phase advances on valid words and wraps at period-1; stays 0 while disabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= '0;
    end else if (!in_valid_i) begin
      r_phase <= w_phase;
    end else if ((w_period == '0) || (w_phase >= (w_period - PH_ONE))) begin
      r_phase <= '0;
    end else begin
      r_phase <= w_phase + PH_ONE;
    end
  end

  // One-cycle symbol pipeline; symbol holds across idle cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_sym   <= '0;
      r_out_err   <= 1'b0;
    end else begin
      r_out_valid <= in_valid_i;
      r_out_err   <= w_inject;
      if (in_valid_i) begin
        r_out_sym <= in_sym_i ^ w_flip;
      end
    end
  end

  // Window statistics; clear wins over a same-cycle update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word_ct <= '0;
      r_bad_ct  <= '0;
      r_done    <= 1'b0;
    end else if (clr_i) begin
      r_word_ct <= '0;
      r_bad_ct  <= '0;
      r_done    <= 1'b0;
    end else if (w_count_en) begin
      r_word_ct <= r_word_ct + CNT_ONE;
      r_bad_ct  <= w_bad_next;
      if (r_word_ct == WIN_LAST) begin
        r_done <= 1'b1;
      end
    end
  end

`ifdef CHAN_PER_BIT_CNT_EN
  logic [CNT_W-1:0] r_bit_ct [SYM_W];

  for (genvar b = 0; b < SYM_W; b++) begin : g_bit_ct
    // Flips at this bit position within the window, saturating
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_bit_ct[b] <= '0;
      end else if (clr_i) begin
        r_bit_ct[b] <= '0;
      end else if (w_count_en && w_flip[b] && (r_bit_ct[b] != '1)) begin
        r_bit_ct[b] <= r_bit_ct[b] + CNT_ONE;
      end
    end
    assign bit_err_ct_o[b] = r_bit_ct[b];
  end
`endif

  assign out_valid_o   = r_out_valid;
  assign out_sym_o     = r_out_sym;
  assign out_err_o     = r_out_err;
  assign word_ct_o     = r_word_ct;
  assign bad_bit_ct_o  = r_bad_ct;
  assign window_done_o = r_done;

endmodule
